// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter driving the select pair of a 4:1 data mux.
// A grant is held until release, requester withdrawal or hold expiry, then a one-cycle gap follows.
module rr_mux_select_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       release_i,
    output logic       s0,
    output logic       s1,
    output logic [3:0] grant,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [1:0]       ST_IDLE   = 2'd0;
    localparam logic [1:0]       ST_GRANT  = 2'd1;
    localparam logic [1:0]       ST_GAP    = 2'd2;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic             HOLD_EN   = (MAX_HOLD != 0) ? 1'b1 : 1'b0;

    logic [1:0]       state_r, state_s;
    logic [1:0]       last_ptr_r, last_ptr_s;
    logic [1:0]       sel_r, sel_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [3:0]       grant_r, grant_s;
    logic             gnt_valid_r, gnt_valid_s;
    logic             timeout_r, timeout_s;
    logic [1:0]       pick_s;
    logic             withdraw_s;
    logic             expire_s;

    // First requesting channel after the last winner, wrapping around.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] cand;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_s     = state_r;
        last_ptr_s  = last_ptr_r;
        sel_s       = sel_r;
        hold_cnt_s  = hold_cnt_r;
        grant_s     = grant_r;
        gnt_valid_s = gnt_valid_r;
        timeout_s   = 1'b0;
        pick_s      = rr_pick(req, last_ptr_r);
        withdraw_s  = ~req[sel_r];
        expire_s    = HOLD_EN && (hold_cnt_r == HOLD_LAST);
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_s     = ST_GRANT;
                    sel_s       = pick_s;
                    grant_s     = 4'b0001 << pick_s;
                    gnt_valid_s = 1'b1;
                    last_ptr_s  = pick_s;
                    hold_cnt_s  = {CNT_W{1'b0}};
                end else begin
                    state_s     = ST_IDLE;
                    grant_s     = 4'b0000;
                    gnt_valid_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_i || withdraw_s || expire_s) begin
                    state_s     = ST_GAP;
                    grant_s     = 4'b0000;
                    gnt_valid_s = 1'b0;
                    timeout_s   = expire_s && !release_i && !withdraw_s;
                end else if (hold_cnt_r != CNT_MAX) begin
                    hold_cnt_s  = hold_cnt_r + CNT_W'(1);
                end else begin
                    hold_cnt_s  = hold_cnt_r;
                end
            end
            // Select lines keep the old index through the gap so the mux output does not glitch.
            ST_GAP: begin
                state_s     = ST_IDLE;
                grant_s     = 4'b0000;
                gnt_valid_s = 1'b0;
            end
            default: begin
                state_s     = ST_IDLE;
                grant_s     = 4'b0000;
                gnt_valid_s = 1'b0;
                hold_cnt_s  = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset gives channel 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_ptr_r  <= 2'd3;
            sel_r       <= 2'd0;
            hold_cnt_r  <= {CNT_W{1'b0}};
            grant_r     <= 4'b0000;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            last_ptr_r  <= last_ptr_s;
            sel_r       <= sel_s;
            hold_cnt_r  <= hold_cnt_s;
            grant_r     <= grant_s;
            gnt_valid_r <= gnt_valid_s;
            timeout_r   <= timeout_s;
        end
    end

    assign s0        = sel_r[0];
    assign s1        = sel_r[1];
    assign grant     = grant_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural arbiter model.
module tb_rr_mux_select_arbiter;

    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       release_i;
    logic       s0, s1, gnt_valid, timeout;
    logic [3:0] grant;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // model: who owns the mux, for how many visible cycles, and who won last
    int         owner;
    int         last;
    int         held;
    bit         in_gap;
    int         waits [4];
    logic [1:0] e_sel;
    logic [3:0] e_grant;
    logic       e_valid;
    logic       e_to;

    rr_mux_select_arbiter #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .release_i(release_i),
        .s0(s0), .s1(s1), .grant(grant), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; last = 3; held = 0; in_gap = 1'b0;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        e_sel = 2'd0; e_grant = 4'd0; e_valid = 1'b0; e_to = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic rl);
        int c;
        int cc;
        c = -1;
        e_to = 1'b0;
        for (int i = 0; i < 4; i++) if (!r[i]) waits[i] = 0;
        if (in_gap) begin
            in_gap = 1'b0;
        end else if (owner < 0) begin
            if (r != 4'd0) begin
                for (int k = 1; k <= 4; k++) begin
                    cc = (last + k) % 4;
                    if (c < 0 && r[cc]) c = cc;
                end
                for (int i = 0; i < 4; i++) begin
                    if (i != c && r[i]) begin
                        waits[i]++;
                        chk("starve", int'(waits[i] <= 3), 1);
                    end
                end
                waits[c] = 0;
                owner = c; last = c; held = 1;
                e_sel = 2'(c); e_grant = 4'b0001 << c; e_valid = 1'b1;
            end
        end else begin
            if (rl || !r[owner] || (MAXH != 0 && held == MAXH)) begin
                e_to = !rl && r[owner];
                owner = -1; in_gap = 1'b1;
                e_grant = 4'd0; e_valid = 1'b0;
            end else begin
                held++;
            end
        end
    endtask

    // One clock: apply inputs after a falling edge, advance model at the rising edge, return at the next falling edge.
    task automatic step(input logic [3:0] r, input logic rl);
        req = r; release_i = rl;
        @(posedge clk);
        model_edge(r, rl);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = 4'd0; release_i = 1'b0; rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("sel", int'({s1, s0}), int'(e_sel));
            chk("grant", int'(grant), int'(e_grant));
            chk("gnt_valid", int'(gnt_valid), int'(e_valid));
            chk("timeout", int'(timeout), int'(e_to));
            if (gnt_valid) chk("onehot_sel", int'($onehot(grant) && grant[{s1, s0}]), 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [$];
        int n;
        logic prev_v;
        logic [3:0] r;
        rst = 1'b1; req = 4'd0; release_i = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_grant", int'(grant), 0);
        chk("reset_valid", int'(gnt_valid), 0);
        chk("reset_sel", int'({s1, s0}), 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // round-robin order with release on the third grant cycle
        do_reset();
        prev_v = 1'b0;
        n = 0;
        while (seq.size() < 5 && n < 80) begin
            step(4'b1111, (owner >= 0 && held == 3));
            if (gnt_valid && !prev_v) seq.push_back(int'({s1, s0}));
            prev_v = gnt_valid;
            n++;
        end
        chk("rr_count", seq.size(), 5);
        if (seq.size() == 5) begin
            chk("rr_0", seq[0], 0); chk("rr_1", seq[1], 1); chk("rr_2", seq[2], 2);
            chk("rr_3", seq[3], 3); chk("rr_4", seq[4], 0);
        end

        // hold expiry on a lone requester
        do_reset();
        step(4'b0100, 1'b0);
        n = 0;
        while (gnt_valid && n < 20) begin
            n++;
            step(4'b0100, 1'b0);
        end
        chk("hold_cycles", n, 8);
        chk("expiry_timeout", int'(timeout), 1);
        step(4'b0100, 1'b0);
        chk("after_gap_idle", int'(gnt_valid), 0);
        step(4'b0100, 1'b0);
        chk("regrant_ch2", int'(grant), 4'b0100);

        // requester withdraws while another waits
        do_reset();
        step(4'b0010, 1'b0);
        chk("ch1_grant", int'(grant), 4'b0010);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b1000, 1'b0);
        chk("withdraw_gap", int'(gnt_valid), 0);
        chk("withdraw_no_to", int'(timeout), 0);
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        chk("ch3_grant", int'(grant), 4'b1000);
        chk("ch3_sel", int'({s1, s0}), 3);

        // release coinciding with hold expiry
        do_reset();
        step(4'b0100, 1'b0);
        for (int i = 1; i < 8; i++) step(4'b0100, 1'b0);
        chk("coinc_valid_before", int'(gnt_valid), 1);
        step(4'b0100, 1'b1);
        chk("coinc_gap", int'(gnt_valid), 0);
        chk("coinc_no_to", int'(timeout), 0);

        // asynchronous reset in the middle of a grant
        do_reset();
        step(4'b0100, 1'b0);
        chk("pre_rst_grant", int'(grant), 4'b0100);
        #2 rst = 1'b1;
        #1;
        chk("async_grant", int'(grant), 0);
        chk("async_valid", int'(gnt_valid), 0);
        chk("async_sel", int'({s1, s0}), 0);
        model_reset();
        req = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111, 1'b0);
        chk("post_rst_ch0", int'(grant), 4'b0001);

        // random traffic
        do_reset();
        r = 4'd0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r, ($urandom_range(0, 7) == 0));
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
